signed_divider_seq: RTL and testbench

- Multi-cycle signed integer divider for the 8-bit calculator datapath.
- Performs restoring shift-and-subtract, the inverse of the add/sub unit's accumulation.
- Sits beside the add/sub unit behind the operation select.
- Accepts one operand pair per start, iterates one quotient bit per clock, and reports quotient, remainder and status with a done pulse.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/signed_divider_seq_div_step.sv | 36 +++
 rtl/signed_divider_seq.sv | 163 ++++++++++++++++
 tb/tb_signed_divider_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared across the 8-bit calculator datapath.
//   - DEFAULT_WIDTH : default operand width for the arithmetic units
//   - div_state_t   : control states of the sequential divider
//   - negate/absVal : two's-complement helpers, also used by the add/sub unit
// The helpers work on a 32-bit word. Callers sign- or zero-extend their
// operands into word_t and size-cast the result back to their own width.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int WORD_BITS     = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

  // Two's-complement negation (invert and add one).
  function automatic word_t negate(input word_t x);
    return ~x + word_t'(1);
  endfunction

  // Absolute value of a sign-extended word. The caller keeps enough bits that
  // the most-negative operand of its own width still has a magnitude that fits.
  function automatic word_t absVal(input word_t x);
    return x[WORD_BITS-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/signed_divider_seq_div_step.sv
// div_step: one combinational restoring-division step.
// The partial remainder and the next dividend bit are shifted together, and
// the divisor magnitude is trial-subtracted with a WIDTH+1-bit subtractor.
// The borrow out decides whether the subtraction is kept.
//   rem_i    [WIDTH-1:0] : current partial remainder (always < |b|)
//   dvdMsb_i             : dividend bit shifted in this step
//   bMag_i   [WIDTH:0]   : divisor magnitude (|b| may be 2^(WIDTH-1))
//   rem_o    [WIDTH-1:0] : partial remainder after this step
//   qBit_o               : quotient bit produced by this step
module div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvdMsb_i,
  input  logic [WIDTH:0]   bMag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qBit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           borrow;

  // A borrow means the shifted remainder is smaller than |b|, so the
  // subtraction is discarded. Whichever value is kept is below |b|, and
  // |b| <= 2^(WIDTH-1), so it fits back into WIDTH bits.
  always_comb begin
    shifted         = {rem_i, dvdMsb_i};
    {borrow, trial} = {1'b0, shifted} - {1'b0, bMag_i};
    qBit_o          = ~borrow;
    rem_o           = WIDTH'(qBit_o ? trial : shifted);
  end

endmodule

// File: rtl/signed_divider_seq.sv
// signed_divider_seq: multi-cycle signed restoring divider, one quotient bit
// per clock. The result truncates toward zero: a = q*b + r, and r has the
// sign of a.
//   clk, rst_n   : clock; asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   a, b         : signed dividend and divisor (WIDTH bits)
//   busy         : high in RUN and FIX
//   done         : one-cycle pulse; q, r and the flags are valid from then on
//   q, r         : signed quotient and remainder
//   div_by_zero  : b was zero (sticky until the next accept)
//   overflow     : most-negative / -1 (sticky until the next accept)
// Build option: defining DIV_FAST_ZERO_EN sends a zero dividend with a
// nonzero divisor straight to DONE. Without it, a zero dividend takes the
// full iteration.
module signed_divider_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   bMag_q;
  logic             signA_q;
  logic             signQ_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             dbz_q;
  logic             ovf_q;

  logic [WIDTH-1:0] rem_d;
  logic             qBit_d;
  logic [WIDTH-1:0] qFix;
  logic [WIDTH-1:0] rFix;
  logic             ovfFix;
  word_t            aExt;
  word_t            bExt;

  assign aExt = word_t'(signed'(a));
  assign bExt = word_t'(signed'(b));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .dvdMsb_i(dvd_q[WIDTH-1]),
    .bMag_i  (bMag_q),
    .rem_o   (rem_d),
    .qBit_o  (qBit_d)
  );

  // Sign fix-up. After the last step, dvd_q holds the magnitude quotient and
  // rem_q the magnitude remainder. A positive quotient of 2^(WIDTH-1) can
  // only come from most-negative / -1. It wraps to most-negative when
  // truncated to WIDTH bits and sets the overflow flag.
  always_comb begin
    qFix   = WIDTH'(signQ_q ? negate(word_t'(dvd_q)) : word_t'(dvd_q));
    rFix   = WIDTH'(signA_q ? negate(word_t'(rem_q)) : word_t'(rem_q));
    ovfFix = !signQ_q && (dvd_q == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // Control FSM with registered outputs. The dividend register shifts left
  // every RUN cycle: its MSB feeds the step and the new quotient bit enters
  // at the LSB, so after WIDTH steps it holds the magnitude quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      bMag_q  <= '0;
      signA_q <= 1'b0;
      signQ_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            signA_q <= a[WIDTH-1];
            signQ_q <= a[WIDTH-1] ^ b[WIDTH-1];
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= WIDTH'(absVal(aExt));
            bMag_q  <= (WIDTH+1)'(absVal(bExt));
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            if (b == '0) begin
              q_q     <= '0;
              r_q     <= a;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
`ifdef DIV_FAST_ZERO_EN
            else if (a == '0) begin
              q_q     <= '0;
              r_q     <= '0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
`endif
            else begin
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= {dvd_q[WIDTH-2:0], qBit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          q_q     <= qFix;
          r_q     <= rFix;
          ovf_q   <= ovfFix;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Testbench for signed_divider_seq. It uses directed vectors with
// hand-computed expected results. Each accepted request pushes its expected
// response, stamped with the accept time, into a scoreboard queue. A monitor
// pops the queue on every done pulse and checks q, r, both flags and the
// latency (rising edges counted from and including the accept edge).
module tb_signed_divider_seq;

  localparam int WIDTH = 8;
`ifdef DIV_FAST_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 10;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;
  logic             overflow;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    logic             ovf;
    int               lat;
    time              acceptTime;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   busyCount = 0;

  signed_divider_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // One comparison. Values are carried as 32-bit signed so that X/Z stay
  // visible and negative results print naturally.
  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Presents one request for a single cycle and records the expected
  // response once the accept edge has passed.
  task automatic applyStimulus(input string name, input int aIn, input int bIn,
                               input int expQ, input int expR, input logic expDbz,
                               input logic expOvf, input int expLat);
    exp_t e;
    @(negedge clk);
    a     = WIDTH'(aIn);
    b     = WIDTH'(bIn);
    start = 1'b1;
    @(posedge clk);
    e.name       = name;
    e.q          = WIDTH'(expQ);
    e.r          = WIDTH'(expR);
    e.dbz        = expDbz;
    e.ovf        = expOvf;
    e.lat        = expLat;
    e.acceptTime = $time;
    sb.push_back(e);
    #1 start = 1'b0;
  endtask

  // Waits, with a bounded cycle budget, until the monitor has consumed every
  // pending expectation.
  task automatic waitDone(input string name);
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s.timeout: got no done within %0d cycles, expected done", name, budget);
      sb.delete();
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpectedDone: got done=1, expected done=0");
      end else begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = int'((($time - e.acceptTime) - 5) / 10) + 1;
        checkOutput({e.name, ".q"}, $signed(q), $signed(e.q));
        checkOutput({e.name, ".r"}, $signed(r), $signed(e.r));
        checkOutput({e.name, ".dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        checkOutput({e.name, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
        checkOutput({e.name, ".latency"}, lat, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busyCount++;
  end

  // Checks that every output is at its reset value.
  task automatic checkResetValues(input string name);
    checkOutput({name, ".q"}, $signed(q), 0);
    checkOutput({name, ".r"}, $signed(r), 0);
    checkOutput({name, ".busy"}, {31'd0, busy}, 0);
    checkOutput({name, ".done"}, {31'd0, done}, 0);
    checkOutput({name, ".dbz"}, {31'd0, div_by_zero}, 0);
    checkOutput({name, ".ovf"}, {31'd0, overflow}, 0);
  endtask

  initial begin
    exp_t e;
    repeat (2) @(negedge clk);
    checkResetValues("resetState");
    rst_n = 1'b1;

    // Basic divide plus the busy window (RUN + FIX = 9 cycles)
    busyCount = 0;
    applyStimulus("p100_p7", 100, 7, 14, 2, 1'b0, 1'b0, 10);
    waitDone("p100_p7");
    checkOutput("p100_p7.busyCycles", busyCount, 9);

    // Sign combinations: q truncates toward zero, r follows the sign of a
    applyStimulus("m100_p7", -100, 7, -14, -2, 1'b0, 1'b0, 10);
    waitDone("m100_p7");
    applyStimulus("p100_m7", 100, -7, -14, 2, 1'b0, 1'b0, 10);
    waitDone("p100_m7");
    applyStimulus("m100_m7", -100, -7, 14, -2, 1'b0, 1'b0, 10);
    waitDone("m100_m7");

    // Most-negative operand boundaries
    applyStimulus("m128_m1", -128, -1, -128, 0, 1'b0, 1'b1, 10);
    waitDone("m128_m1");
    applyStimulus("m128_p1", -128, 1, -128, 0, 1'b0, 1'b0, 10);
    waitDone("m128_p1");
    applyStimulus("m128_m128", -128, -128, 1, 0, 1'b0, 1'b0, 10);
    waitDone("m128_m128");
    applyStimulus("p127_m128", 127, -128, 0, 127, 1'b0, 1'b0, 10);
    waitDone("p127_m128");
    applyStimulus("m128_p7", -128, 7, -18, -2, 1'b0, 1'b0, 10);
    waitDone("m128_p7");

    // Divide by zero, then a normal divide that must clear the flag
    applyStimulus("p55_z", 55, 0, 0, 55, 1'b1, 1'b0, 1);
    waitDone("p55_z");
    applyStimulus("p9_p3", 9, 3, 3, 0, 1'b0, 1'b0, 10);
    waitDone("p9_p3");

    // Abort: a start while busy is ignored, then reset mid-operation
    @(negedge clk);
    a     = 8'd100;
    b     = 8'd7;
    start = 1'b1;
    @(posedge clk);
    e.name       = "aborted";
    e.q          = 8'd14;
    e.r          = 8'd2;
    e.dbz        = 1'b0;
    e.ovf        = 1'b0;
    e.lat        = 10;
    e.acceptTime = $time;
    sb.push_back(e);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    a     = 8'd1;
    b     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkResetValues("asyncReset");
    repeat (3) begin
      @(negedge clk);
      checkOutput("resetHold.done", {31'd0, done}, 0);
    end
    rst_n = 1'b1;
    applyStimulus("m7_p2", -7, 2, -3, -1, 1'b0, 1'b0, 10);
    waitDone("m7_p2");

    // Zero dividend (latency depends on the build option)
    applyStimulus("z_p5", 0, 5, 0, 0, 1'b0, 1'b0, ZERO_LAT);
    waitDone("z_p5");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
